// File: rtl/axi_hp_slave_mem.sv
// AXI4 burst slave backed by on-chip RAM. Independent read and write engines,
// one burst in flight per direction; read data returned through a 2-entry skid FIFO.
module axi_hp_slave_mem #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 64,
  parameter int unsigned       ID_W      = 4,
  parameter int unsigned       MEM_AW    = 11,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_aresetn,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef logic [ADDR_W+1:0] addr_ext_t;
  typedef logic [MEM_AW-1:0] idx_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_ent_t;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RBurst} r_state_e;

  // Whole burst must land inside the RAM window; checked once at the address handshake.
  function automatic logic burst_err(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
    addr_ext_t span, lim;
    span = (burst == BurstFixed) ? addr_ext_t'(8) : (addr_ext_t'(len) + addr_ext_t'(1)) << 3;
    lim  = addr_ext_t'(BASE_ADDR) + (addr_ext_t'(1) << (MEM_AW + 3));
    return (size != 3'd3) || (burst == BurstWrap) || (addr[2:0] != 3'b000) ||
           (addr < BASE_ADDR) || (addr_ext_t'(addr) + span > lim);
  endfunction

  function automatic idx_t word_idx(input logic [ADDR_W-1:0] addr);
    return idx_t'((addr - BASE_ADDR) >> 3);
  endfunction

  logic [DATA_W-1:0] ram [2**MEM_AW];

  // Write engine
  w_state_e        w_state_q, w_state_d;
  logic            awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic [ID_W-1:0] bid_q, bid_d;
  idx_t            w_idx_q, w_idx_d;
  logic [7:0]      w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic            w_fixed_q, w_fixed_d, w_err_q, w_err_d;
  logic            ram_we;

  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_fixed_d = w_fixed_q;
    w_err_d   = w_err_q;
    ram_we    = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        awready_d = 1'b1;
        if (s_axi_awvalid && awready_q) begin
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = WData;
          bid_d     = s_axi_awid;
          w_idx_d   = word_idx(s_axi_awaddr);
          w_len_d   = s_axi_awlen;
          w_beat_d  = 8'd0;
          w_fixed_d = (s_axi_awburst == BurstFixed);
          w_err_d   = burst_err(s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst);
        end
      end
      WData: begin
        if (s_axi_wvalid && wready_q) begin
          // Once err is set (illegal burst or overrun past awlen) beats are absorbed unwritten.
          ram_we   = !w_err_q;
          w_beat_d = w_beat_q + 8'd1;
          if (!w_fixed_q) w_idx_d = w_idx_q + idx_t'(1);
          if (s_axi_wlast) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            w_state_d = WResp;
            bresp_d   = (w_err_q || (w_beat_q != w_len_q)) ? RespSlvErr : RespOkay;
          end else if (w_beat_q == w_len_q) begin
            w_err_d = 1'b1;
          end
        end
      end
      WResp: begin
        if (s_axi_bready && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      w_state_q <= WIdle;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      bid_q     <= '0;
      w_idx_q   <= '0;
      w_len_q   <= 8'd0;
      w_beat_q  <= 8'd0;
      w_fixed_q <= 1'b0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_fixed_q <= w_fixed_d;
      w_err_q   <= w_err_d;
    end
  end

  // RAM contents survive reset; the read path below samples the pre-write value (read-first).
  always_ff @(posedge s_axi_aclk) begin
    if (ram_we && s_axi_aresetn) begin
      for (int unsigned b = 0; b < DATA_W / 8; b++) begin
        if (s_axi_wstrb[b]) ram[w_idx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // Read engine
  r_state_e        r_state_q, r_state_d;
  logic            arready_q, arready_d;
  logic [ID_W-1:0] rid_q, rid_d;
  idx_t            r_idx_q, r_idx_d;
  logic [7:0]      r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic            r_fixed_q, r_fixed_d, r_err_q, r_err_d, r_done_q, r_done_d;
  r_ent_t          head_q, head_d, spare_q, spare_d, r_push;
  logic            head_v_q, head_v_d, spare_v_q, spare_v_d;
  logic            r_pop, r_issue;

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rid_d     = rid_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_fixed_d = r_fixed_q;
    r_err_d   = r_err_q;
    r_done_d  = r_done_q;
    r_pop     = head_v_q && s_axi_rready;
    // Issue only when the FIFO is guaranteed a free slot after this cycle's pop.
    r_issue   = (r_state_q == RBurst) && !r_done_q && (!spare_v_q || r_pop);
    r_push.data = r_err_q ? '0 : ram[r_idx_q];
    r_push.resp = r_err_q ? RespSlvErr : RespOkay;
    r_push.last = (r_beat_q == r_len_q);
    unique case (r_state_q)
      RIdle: begin
        arready_d = 1'b1;
        if (s_axi_arvalid && arready_q) begin
          arready_d = 1'b0;
          r_state_d = RBurst;
          rid_d     = s_axi_arid;
          r_idx_d   = word_idx(s_axi_araddr);
          r_len_d   = s_axi_arlen;
          r_beat_d  = 8'd0;
          r_done_d  = 1'b0;
          r_fixed_d = (s_axi_arburst == BurstFixed);
          r_err_d   = burst_err(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
        end
      end
      RBurst: begin
        if (r_issue) begin
          r_beat_d = r_beat_q + 8'd1;
          if (!r_fixed_q) r_idx_d = r_idx_q + idx_t'(1);
          if (r_push.last) r_done_d = 1'b1;
        end
        if (r_pop && head_q.last) begin
          r_state_d = RIdle;
          arready_d = 1'b1;
        end
      end
    endcase

    head_d    = head_q;
    head_v_d  = head_v_q;
    spare_d   = spare_q;
    spare_v_d = spare_v_q;
    if (r_pop) begin
      head_d    = spare_q;
      head_v_d  = spare_v_q;
      spare_v_d = 1'b0;
    end
    if (r_issue) begin
      if (!head_v_d) begin
        head_d   = r_push;
        head_v_d = 1'b1;
      end else begin
        spare_d   = r_push;
        spare_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_state_q <= RIdle;
      arready_q <= 1'b0;
      rid_q     <= '0;
      r_idx_q   <= '0;
      r_len_q   <= 8'd0;
      r_beat_q  <= 8'd0;
      r_fixed_q <= 1'b0;
      r_err_q   <= 1'b0;
      r_done_q  <= 1'b0;
      head_q    <= '0;
      head_v_q  <= 1'b0;
      spare_q   <= '0;
      spare_v_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rid_q     <= rid_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_fixed_q <= r_fixed_d;
      r_err_q   <= r_err_d;
      r_done_q  <= r_done_d;
      head_q    <= head_d;
      head_v_q  <= head_v_d;
      spare_q   <= spare_d;
      spare_v_q <= spare_v_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = head_v_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = head_q.data;
  assign s_axi_rresp   = head_q.resp;
  assign s_axi_rlast   = head_q.last;

endmodule

// File: tb/tb_axi_hp_slave_mem.sv
// Self-checking bench for axi_hp_slave_mem: directed bursts plus randomized traffic,
// compared against a word-array memory model and the AXI response rules.
module tb_axi_hp_slave_mem;
  localparam int     WORDS = 2048;
  localparam longint BASE  = 0;
  localparam int     TO    = 300;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  awid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0;
  logic [7:0]  awlen = '0, arlen = '0, wstrb = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
  logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid, rlast;
  logic [63:0] wdata = '0, rdata;

  always #5 clk = ~clk;

  axi_hp_slave_mem #(
    .ADDR_W(32), .DATA_W(64), .ID_W(4), .MEM_AW(11), .BASE_ADDR(32'h0000_0000)
  ) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rstn),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready), .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  int          n_assert = 0;
  int          n_fail = 0;
  logic [63:0] model [WORDS];
  logic [63:0] wd [256];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit illegal(input logic [31:0] addr, input int len, input logic [2:0] size,
                                 input logic [1:0] burst);
    longint a, e;
    a = longint'(addr);
    e = (burst == 2'b00) ? a + 8 : a + 8 * (len + 1);
    return (size != 3'd3) || (burst == 2'b10) || (addr[2:0] != 3'b000) || (a < BASE) ||
           (e > BASE + 8 * WORDS);
  endfunction

  function automatic int widx(input logic [31:0] addr);
    return int'((longint'(addr) - BASE) / 8);
  endfunction

  task automatic aw_hs(input logic [31:0] addr, input int len, input logic [1:0] burst,
                       input logic [2:0] size, input logic [3:0] id, input string tag);
    int t;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (!awready && t < TO) begin @(negedge clk); t++; end
    check({tag, " awready"}, 128'(t < TO), 128'(1));
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic ar_hs(input logic [31:0] addr, input int len, input logic [1:0] burst,
                       input logic [2:0] size, input logic [3:0] id, input string tag);
    int t;
    @(negedge clk);
    arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    while (!arready && t < TO) begin @(negedge clk); t++; end
    check({tag, " arready"}, 128'(t < TO), 128'(1));
    @(posedge clk); #1 arvalid = 1'b0;
  endtask

  // nbeats != len+1 produces an early or missing wlast; wlast always on the final sent beat.
  task automatic write_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                             input logic [2:0] size, input int nbeats, input logic [7:0] strb,
                             input string tag);
    logic [3:0] id;
    logic [1:0] exp_resp;
    bit         bad, done;
    int         t, acc, idx;
    id = 4'($urandom);
    bad = illegal(addr, len, size, burst);
    exp_resp = (bad || nbeats != len + 1) ? 2'b10 : 2'b00;
    aw_hs(addr, len, burst, size, id, tag);
    acc = 0;
    for (int i = 0; i < nbeats; i++) begin
      @(negedge clk);
      while ($urandom_range(3) == 0) @(negedge clk);
      wvalid = 1'b1; wdata = wd[i]; wstrb = strb; wlast = (i == nbeats - 1);
      t = 0;
      while (!wready && t < TO) begin @(negedge clk); t++; end
      @(posedge clk); #1 wvalid = 1'b0; wlast = 1'b0;
      if (t >= TO) break;
      acc++;
    end
    check({tag, " wbeats"}, 128'(acc), 128'(nbeats));
    if (!bad) begin
      for (int i = 0; i < nbeats && i <= len; i++) begin
        idx = widx(addr) + ((burst == 2'b00) ? 0 : i);
        for (int b = 0; b < 8; b++) if (strb[b]) model[idx][8*b +: 8] = wd[i][8*b +: 8];
      end
    end
    t = 0; done = 1'b0;
    while (t < TO && !done) begin
      @(negedge clk); t++;
      bready = 1'($urandom_range(1));
      if (bvalid && bready) begin
        check({tag, " b"}, 128'({bid, bresp, awready, wready}), 128'({id, exp_resp, 2'b00}));
        done = 1'b1;
      end
    end
    check({tag, " b seen"}, 128'(done), 128'(1));
    @(posedge clk); #1 bready = 1'b0;
    @(negedge clk);
    check({tag, " aw reopen"}, 128'({awready, bvalid}), 128'(2'b10));
  endtask

  // mode 0: rready held high; 1: toggles each cycle; 2: random.
  task automatic read_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic [2:0] size, input int mode, input string tag);
    logic [3:0]  id;
    logic [63:0] exp;
    logic [71:0] saved;
    bit          bad, stall;
    int          t, got, first, budget;
    id = 4'($urandom);
    bad = illegal(addr, len, size, burst);
    ar_hs(addr, len, burst, size, id, tag);
    got = 0; t = 0; first = -1; stall = 1'b0; saved = '0;
    budget = 4 * (len + 1) + 50;
    while (got <= len && t < budget) begin
      @(negedge clk); t++;
      if (stall) check({tag, " stable"}, 128'({rvalid, rid, rresp, rlast, rdata}), 128'(saved));
      if (rvalid && first < 0) first = t;
      rready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(t % 2) : 1'($urandom_range(1));
      if (rvalid && rready) begin
        exp = bad ? 64'd0 : model[widx(addr) + ((burst == 2'b00) ? 0 : got)];
        check({tag, " beat"}, 128'({rid, rresp, rlast, rdata}),
              128'({id, bad ? 2'b10 : 2'b00, (got == len) ? 1'b1 : 1'b0, exp}));
        got++;
      end
      stall = rvalid && !rready;
      saved = {rvalid, rid, rresp, rlast, rdata};
    end
    check({tag, " beats"}, 128'(got), 128'(len + 1));
    if (mode == 0) begin
      check({tag, " first latency"}, 128'(first), 128'(2));
      check({tag, " throughput"}, 128'(t), 128'(len + 2));
    end
    @(posedge clk); #1 rready = 1'b0;
    @(negedge clk);
    check({tag, " ar reopen"}, 128'({arready, rvalid}), 128'(2'b10));
  endtask

  initial begin
    logic [31:0] a;
    int          len, t;
    logic [1:0]  bt;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset outputs", 128'({awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp}),
          128'(0));
    rstn = 1'b1;
    @(negedge clk);
    check("reset release", 128'({awready, arready, wready, bvalid, rvalid}), 128'(5'b11000));

    // Fill all of RAM so the model is fully known
    for (int k = 0; k < WORDS / 128; k++) begin
      for (int i = 0; i < 128; i++) wd[i] = {$urandom, $urandom};
      write_burst(32'(k * 1024), 127, 2'b01, 3'd3, 128, 8'hFF, "fill");
    end

    // 128-beat INCR write of beat index, then read back unstalled and with toggled rready
    for (int i = 0; i < 128; i++) wd[i] = 64'(i);
    write_burst(32'h0, 127, 2'b01, 3'd3, 128, 8'hFF, "w128");
    read_burst(32'h0, 127, 2'b01, 3'd3, 0, "r128");
    read_burst(32'h0, 127, 2'b01, 3'd3, 1, "r128 toggle");

    // Randomized legal INCR/FIXED bursts with random strobes
    for (int n = 0; n < 8; n++) begin
      a   = 32'($urandom_range(400, 1880) * 8);
      len = $urandom_range(0, 15);
      bt  = 2'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) wd[i] = {$urandom, $urandom};
      write_burst(a, len, bt, 3'd3, len + 1, 8'($urandom), "rand w");
      read_burst(a, len, bt, 3'd3, 2, "rand r");
    end

    // Partial strobe over all-ones word
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    write_burst(32'(150 * 8), 0, 2'b01, 3'd3, 1, 8'hFF, "ones");
    wd[0] = {$urandom, $urandom};
    write_burst(32'(150 * 8), 0, 2'b01, 3'd3, 1, 8'h0F, "strb0f");
    read_burst(32'(150 * 8), 0, 2'b01, 3'd3, 0, "strb0f rd");

    // Illegal bursts: past end of RAM, misaligned, bad size; WRAP and bad-size reads
    wd[0] = {$urandom, $urandom};
    write_burst(32'((WORDS - 1) * 8), 0, 2'b01, 3'd3, 1, 8'hFF, "last word");
    for (int i = 0; i < 2; i++) wd[i] = {$urandom, $urandom};
    write_burst(32'((WORDS - 1) * 8), 1, 2'b01, 3'd3, 2, 8'hFF, "oob w");
    read_burst(32'((WORDS - 1) * 8), 0, 2'b01, 3'd3, 0, "oob unchanged");
    write_burst(32'h4, 0, 2'b01, 3'd3, 1, 8'hFF, "misaligned w");
    write_burst(32'h8, 0, 2'b01, 3'd2, 1, 8'hFF, "size2 w");
    read_burst(32'h0, 3, 2'b10, 3'd3, 0, "wrap r");
    read_burst(32'h10, 2, 2'b01, 3'd2, 2, "size2 r");

    // Early wlast (beat 2 of len 7) and missing wlast (10 beats for len 7)
    for (int i = 0; i < 10; i++) wd[i] = {$urandom, $urandom};
    write_burst(32'(300 * 8), 7, 2'b01, 3'd3, 3, 8'hFF, "early wlast");
    read_burst(32'(300 * 8), 7, 2'b01, 3'd3, 2, "early wlast rd");
    write_burst(32'(308 * 8), 7, 2'b01, 3'd3, 10, 8'hFF, "late wlast");
    read_burst(32'(308 * 8), 7, 2'b01, 3'd3, 2, "late wlast rd");

    // Reset with both engines mid-burst
    ar_hs(32'h0, 15, 2'b01, 3'd3, 4'h5, "mid r");
    repeat (3) @(negedge clk);
    check("mid r rvalid", 128'(rvalid), 128'(1));
    aw_hs(32'(1000 * 8), 15, 2'b01, 3'd3, 4'h6, "mid w");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wvalid = 1'b1; wdata = {$urandom, $urandom}; wstrb = 8'hFF; wlast = 1'b0;
      t = 0;
      while (!wready && t < TO) begin @(negedge clk); t++; end
      check("mid w beat", 128'(t < TO), 128'(1));
      @(posedge clk); #1 wvalid = 1'b0;
    end
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("mid reset outputs",
          128'({awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp}), 128'(0));
    rstn = 1'b1;
    @(negedge clk);
    check("mid reset release", 128'({awready, arready, wready, bvalid, rvalid}),
          128'(5'b11000));
    read_burst(32'h0, 127, 2'b01, 3'd3, 0, "post reset r");
    for (int i = 0; i < 4; i++) wd[i] = {$urandom, $urandom};
    write_burst(32'(500 * 8), 3, 2'b01, 3'd3, 4, 8'hFF, "post reset w");
    read_burst(32'(500 * 8), 3, 2'b01, 3'd3, 1, "post reset rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
